// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: receive FSM state type, oversampling
//                constants, default frame width, baud accumulator limits for
//                the 64 MHz / 115200 configuration and a 3-input majority
//                helper.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int DATA_BITS_DEF = 8;
    localparam int OS_RATE       = 16;
    localparam int MID_SAMPLE    = 8;

    // Baud generator accumulator limits shared by the RX tick and TX tick.
    localparam int RX_ACC_MAX    = 34;
    localparam int TX_ACC_MAX    = 555;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Generic two-flop synchronizer for asynchronous input pins.
//                The reset value is a parameter so idle-high lines such as
//                a UART rx pin come out of reset in their idle level.
//  Ports       : clk    - destination clock
//                rst_n  - asynchronous active-low reset
//                d      - asynchronous input
//                q      - synchronized output
//  Revision    : 1.0  initial release
// ============================================================================
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_os16.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_os16
//  Description : 8N1 UART receiver running from a 16x oversampling tick.
//                Each bit is decided by a 3-sample majority around its
//                centre. Received bytes go to a single-entry valid/ready
//                holding register; framing errors and overruns are flagged
//                with one-cycle pulses.
//  Ports       : clk       - system clock
//                rst_n     - asynchronous active-low reset
//                rxclk_en  - one-cycle oversample tick (16 x baud)
//                rx        - asynchronous serial input, idles high
//                rd_data   - received byte, stable while rd_valid
//                rd_valid  - byte available
//                rd_ready  - consumer accepts byte on rd_valid && rd_ready
//                frame_err - pulse: stop bit sampled low
//                overrun   - pulse: completed byte dropped, holding reg full
//                busy      - frame in progress
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = uart_pkg::DATA_BITS_DEF,
    parameter int OS_RATE    = uart_pkg::OS_RATE,
    parameter int MID_SAMPLE = uart_pkg::MID_SAMPLE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxclk_en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int          BIDX_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [3:0]  SAMP_A   = 4'(MID_SAMPLE - 1);
    localparam logic [3:0]  SAMP_B   = 4'(MID_SAMPLE);
    localparam logic [3:0]  SAMP_C   = 4'(MID_SAMPLE + 1);
    localparam logic [3:0]  CNT_LAST = 4'(OS_RATE - 1);
    localparam logic [BIDX_W-1:0] LAST_BIT = BIDX_W'(DATA_BITS - 1);

    logic rx_s;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync_rx (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    uart_rx_state_t         state_q,     state_d;
    logic [3:0]             cnt_q,       cnt_d;
    logic [BIDX_W-1:0]      bit_idx_q,   bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q,     shift_d;
    logic                   s7_q,        s7_d;
    logic                   s8_q,        s8_d;
    logic [DATA_BITS-1:0]   rd_data_q,   rd_data_d;
    logic                   rd_valid_q,  rd_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q,   overrun_d;

    logic maj;
    logic deliver;
    logic stop_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            s7_q        <= 1'b1;
            s8_q        <= 1'b1;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            s7_q        <= s7_d;
            s8_q        <= s8_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Bit decision: the two earlier samples plus the live one at SAMP_C.
    assign maj = maj3(s7_q, s8_q, rx_s);

    // Receive FSM and sampling; everything here only moves on a tick.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        s7_d      = s7_q;
        s8_d      = s8_q;
        deliver   = 1'b0;
        stop_bad  = 1'b0;

        if (rxclk_en) begin
            if (state_q == START || state_q == DATA || state_q == STOP) begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SAMP_A) s7_d = rx_s;
                if (cnt_q == SAMP_B) s8_d = rx_s;
            end

            case (state_q)
                IDLE: begin
                    // The detection tick is tick 0 of the start bit.
                    if (!rx_s) begin
                        state_d = START;
                        cnt_d   = 4'd1;
                    end
                end
                START: begin
                    if (cnt_q == SAMP_C && maj) begin
                        state_d = IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = DATA;
                        cnt_d     = '0;
                        bit_idx_d = '0;
                    end
                end
                DATA: begin
                    // Shift in at the MSB so the first (LSB) bit ends at bit 0.
                    if (cnt_q == SAMP_C) begin
                        shift_d = {maj, shift_q[DATA_BITS-1:1]};
                    end
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (bit_idx_q == LAST_BIT) begin
                            state_d = STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    // Leave at the stop-bit centre to tolerate baud mismatch
                    // and allow an immediately following start bit.
                    if (cnt_q == SAMP_C) begin
                        if (maj) begin
                            deliver = 1'b1;
                            state_d = IDLE;
                        end else begin
                            stop_bad = 1'b1;
                            state_d  = WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Holding register handshake, evaluated every clock.
    always_comb begin
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_valid_q;
        frame_err_d = stop_bad;
        overrun_d   = 1'b0;

        if (rd_valid_q && rd_ready) begin
            rd_valid_d = 1'b0;
        end
        if (deliver) begin
            if (!rd_valid_q || rd_ready) begin
                rd_data_d  = shift_q;
                rd_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os16.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_os16
//  Description : Self-checking bench for uart_rx_os16. A serial line driver
//                produces 8N1 frames at a chosen bit time; a monitor records
//                every accepted byte and every flag pulse; expected bytes are
//                queued by the stimulus and compared in order.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_os16;

    localparam int BIT_CLK = 560;
    localparam int TICK_DIV = 35;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       rxclk_en = 1'b0;
    logic       rx       = 1'b1;
    logic       rd_ready = 1'b1;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    always #5 clk = ~clk;

    uart_rx_os16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxclk_en  (rxclk_en),
        .rx        (rx),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    // Oversample tick: one clk in every TICK_DIV, can be frozen.
    bit tick_run = 1'b1;
    int tick_div = 0;
    always @(posedge clk) begin
        #1;
        if (tick_div == TICK_DIV - 1) begin
            tick_div = 0;
            rxclk_en = tick_run;
        end else begin
            tick_div = tick_div + 1;
            rxclk_en = 1'b0;
        end
    end

    // Monitor: accepted bytes and flag pulses.
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int n_ferr     = 0;
    int n_ovr      = 0;
    int n_both     = 0;
    int n_busy_bad = 0;
    logic valid_prev = 1'b0;
    always @(negedge clk) begin
        if (rd_valid && rd_ready) got_q.push_back(rd_data);
        if (rd_valid && !valid_prev && busy) n_busy_bad++;
        if (frame_err) n_ferr++;
        if (overrun) n_ovr++;
        if (frame_err && overrun) n_both++;
        valid_prev = rd_valid;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Compare received bytes against the expected stream, then clear both.
    task automatic compare_stream(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check({tag, "_byte"}, got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive the first nbits of an 8N1 frame (start, data LSB first, stop).
    task automatic send_frame(input logic [7:0] b, input logic stop_lvl,
                              input int bt, input int nbits);
        logic [9:0] f;
        f = {stop_lvl, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rx = f[i];
            repeat (bt) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_good(input logic [7:0] b, input int bt);
        exp_q.push_back(b);
        send_frame(b, 1'b1, bt, 10);
    endtask

    initial begin
        int bt;
        logic [7:0] rb;

        // Reset state
        repeat (5) @(posedge clk);
        #1;
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        idle(200);

        // Single byte
        send_good(8'hA5, BIT_CLK);
        idle(100);
        compare_stream("a5");
        check("a5_busy", busy, 0);
        check("a5_ferr", n_ferr, 0);
        check("a5_ovr", n_ovr, 0);

        // Back-to-back
        send_good(8'h00, BIT_CLK);
        send_good(8'hFF, BIT_CLK);
        send_good(8'h55, BIT_CLK);
        idle(100);
        compare_stream("b2b");
        check("b2b_ferr", n_ferr, 0);

        // Short low glitch on an idle line
        rx = 1'b0;
        repeat (3 * TICK_DIV) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (TICK_DIV) @(posedge clk);
        #1;
        check("glitch_busy_mid", busy, 1);
        idle(20 * TICK_DIV);
        check("glitch_busy_end", busy, 0);
        check("glitch_ferr", n_ferr, 0);
        compare_stream("glitch");
        send_good(8'h5A, BIT_CLK);
        idle(100);
        compare_stream("post_glitch");

        // Framing error followed by a stuck-low line
        send_frame(8'h3C, 1'b0, BIT_CLK, 10);
        rx = 1'b0;
        repeat (20 * BIT_CLK) @(posedge clk);
        #1;
        check("ferr_count", n_ferr, 1);
        check("ferr_busy_low", busy, 1);
        check("ferr_no_valid", rd_valid, 0);
        idle(5 * TICK_DIV);
        check("ferr_busy_released", busy, 0);
        compare_stream("ferr");
        send_good(8'h81, BIT_CLK);
        idle(100);
        compare_stream("post_ferr");

        // Overrun with consumer stalled
        rd_ready = 1'b0;
        send_frame(8'h11, 1'b1, BIT_CLK, 10);
        send_frame(8'h22, 1'b1, BIT_CLK, 10);
        idle(100);
        check("ovr_valid", rd_valid, 1);
        check("ovr_data", rd_data, 8'h11);
        check("ovr_count", n_ovr, 1);
        check("ovr_ferr", n_ferr, 1);

        // Ticks frozen: FSM ignores the line, handshake still drains
        tick_run = 1'b0;
        idle(2 * TICK_DIV);
        rx = 1'b0;
        repeat (10 * TICK_DIV) @(posedge clk);
        #1;
        check("freeze_busy", busy, 0);
        rd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("freeze_pop_valid", rd_valid, 0);
        idle(10);
        tick_run = 1'b1;
        idle(20 * TICK_DIV);
        check("freeze_resume_busy", busy, 0);
        exp_q.push_back(8'h11);
        compare_stream("ovr");

        // Reset in the middle of a frame
        send_frame(8'h77, 1'b1, BIT_CLK, 4);
        check("midrst_busy_before", busy, 1);
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("midrst_valid", rd_valid, 0);
        check("midrst_busy", busy, 0);
        rst_n = 1'b1;
        idle(300);
        send_good(8'h96, BIT_CLK);
        idle(100);
        send_good(8'h96, BIT_CLK - BIT_CLK / 40);
        send_good(8'h96, BIT_CLK + BIT_CLK / 40);
        idle(100);
        compare_stream("midrst");

        // Random bytes, back-to-back, small random baud skew
        for (int k = 0; k < 6; k++) begin
            rb = 8'($urandom);
            bt = BIT_CLK - 12 + int'($urandom_range(0, 24));
            send_good(rb, bt);
        end
        idle(100);
        compare_stream("rand");

        check("ferr_total", n_ferr, 1);
        check("ovr_total", n_ovr, 1);
        check("flags_exclusive", n_both, 0);
        check("busy_at_delivery", n_busy_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
